// File: rtl/fir_sink_pkg.sv
// Shared types and helpers for the FIR result sink: serializer states,
// the drop counter ceiling and the result-to-byte-count helper.
package fir_sink_pkg;

    // Serializer states: IDLE waits for a stored result, SEND streams its bytes.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sink_state_t;

    // The drop counter stops here instead of wrapping back to zero.
    localparam logic [15:0] DropMax = 16'hFFFF;

    // Number of bytes needed to carry a result of width w.
    function automatic int n_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding filter results until the serializer takes
// them. It has no drop policy of its own: the parent decides whether a push
// is allowed. A push into a full FIFO is only stored when a pop happens in
// the same cycle, which frees the slot being written.
module result_fifo
    import fir_sink_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] DepthCount = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == DepthCount);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_en    = push && (!full || pop);
        rd_en    = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Result storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers, cleared to an empty FIFO on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fir_result_sink.sv
// Receiving end of the FIR filter output. Each valid result is queued in a
// small FIFO and streamed out LSB byte first over a ready/valid byte port.
// The filter cannot be stalled, so a result arriving with no room is
// dropped and counted rather than back-pressured.
module fir_result_sink
    import fir_sink_pkg::*;
#(
    parameter int OutWidth = 32,
    parameter int Depth    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OutWidth-1:0] result,
    input  logic                valid,
    output logic [7:0]          byte_data,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                byte_last,
    output logic                overflow,
    output logic [15:0]         drop_count,
    input  logic                clear
);

    localparam int NBytes = n_bytes(OutWidth);
    localparam int ShW    = NBytes * 8;
    localparam int IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

    sink_state_t         state_q, state_d;
    logic [ShW-1:0]      shift_q, shift_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                byte_valid_q, byte_valid_d;
    logic                byte_last_q, byte_last_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_count_q, drop_count_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic [OutWidth-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;
    logic                is_last;

    result_fifo #(
        .Width (OutWidth),
        .Depth (Depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (result),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign byte_data  = shift_q[7:0];
    assign byte_valid = byte_valid_q;
    assign byte_last  = byte_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

    // Serializer: load a result, step through its bytes, chain to the next without a bubble.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        is_last  = (idx_q == LastIdx);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = ShW'(fifo_dout);
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (!is_last) begin
                        shift_d = shift_q >> 8;
                        idx_d   = idx_q + IdxW'(1);
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = ShW'(fifo_dout);
                        idx_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        byte_valid_d = (state_d == SEND);
        byte_last_d  = (state_d == SEND) && (idx_d == LastIdx);
    end

    // Push admission and drop bookkeeping; a drop outranks a same-cycle clear.
    always_comb begin
        fifo_push    = valid && (!fifo_full || fifo_pop);
        drop         = valid && !fifo_push;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != DropMax) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (clear) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    // State and output registers; reset abandons any result in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_fir_result_sink.sv
// Directed bench for fir_result_sink: a 32-bit/depth-4 instance carries most
// scenarios, with a 12-bit instance for odd widths and an 8-bit instance for
// single-byte results. Expected bytes are queued when results are driven and
// popped as the design hands bytes over.
module tb_fir_result_sink;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [31:0] result32;
    logic        valid32, byte_ready32, clear32;
    logic [7:0]  byte_data32;
    logic        byte_valid32, byte_last32, overflow32;
    logic [15:0] drop_count32;

    logic [11:0] result12;
    logic        valid12, byte_ready12, clear12;
    logic [7:0]  byte_data12;
    logic        byte_valid12, byte_last12, overflow12;
    logic [15:0] drop_count12;

    logic [7:0]  result8;
    logic        valid8, byte_ready8, clear8;
    logic [7:0]  byte_data8;
    logic        byte_valid8, byte_last8, overflow8;
    logic [15:0] drop_count8;

    int checks = 0;
    int errors = 0;

    logic [8:0] q32[$];
    logic [8:0] q12[$];

    int   cyc        = 0;
    int   validCount = 0;
    int   firstValid = 0;
    int   lastValid  = 0;
    bit   seenValid  = 1'b0;
    bit   stalledPrev = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic       prevLast = 1'b0;

    fir_result_sink #(.OutWidth(32), .Depth(4)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .result     (result32),
        .valid      (valid32),
        .byte_data  (byte_data32),
        .byte_valid (byte_valid32),
        .byte_ready (byte_ready32),
        .byte_last  (byte_last32),
        .overflow   (overflow32),
        .drop_count (drop_count32),
        .clear      (clear32)
    );

    fir_result_sink #(.OutWidth(12), .Depth(4)) dut12 (
        .clk        (clk),
        .rst        (rst),
        .result     (result12),
        .valid      (valid12),
        .byte_data  (byte_data12),
        .byte_valid (byte_valid12),
        .byte_ready (byte_ready12),
        .byte_last  (byte_last12),
        .overflow   (overflow12),
        .drop_count (drop_count12),
        .clear      (clear12)
    );

    fir_result_sink #(.OutWidth(8), .Depth(2)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .result     (result8),
        .valid      (valid8),
        .byte_data  (byte_data8),
        .byte_valid (byte_valid8),
        .byte_ready (byte_ready8),
        .byte_last  (byte_last8),
        .overflow   (overflow8),
        .drop_count (drop_count8),
        .clear      (clear8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected32(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            q32.push_back({(b == 3), w[8*b +: 8]});
        end
    endtask

    task automatic applyStimulus(input logic [31:0] res, input logic v, input logic rdy,
                                 input logic clr, input bit expectStored);
        result32     = res;
        valid32      = v;
        byte_ready32 = rdy;
        clear32      = clr;
        if (v && expectStored) pushExpected32(res);
        @(posedge clk);
        #1;
        valid32 = 1'b0;
        clear32 = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while ((q32.size() != 0 || q12.size() != 0 || byte_valid32 || byte_valid12) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 64'(n < 300), 64'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard and hold monitor for the 32-bit instance.
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (rst && stalledPrev) begin
            checkOutput("holdValid32", 64'(byte_valid32), 64'd1);
            checkOutput("holdData32", 64'(byte_data32), 64'(prevData));
            checkOutput("holdLast32", 64'(byte_last32), 64'(prevLast));
        end
        if (rst && byte_valid32) begin
            if (!seenValid) firstValid = cyc;
            seenValid = 1'b1;
            lastValid = cyc;
            validCount++;
            if (byte_ready32) begin
                checkOutput("byteExpected32", 64'(q32.size() > 0), 64'd1);
                if (q32.size() > 0) begin
                    e = q32.pop_front();
                    checkOutput("byteData32", 64'(byte_data32), 64'(e[7:0]));
                    checkOutput("byteLast32", 64'(byte_last32), 64'(e[8]));
                end
            end
        end
        stalledPrev = rst && byte_valid32 && !byte_ready32;
        prevData    = byte_data32;
        prevLast    = byte_last32;
    end

    // Scoreboard for the 12-bit instance.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst && byte_valid12 && byte_ready12) begin
            checkOutput("byteExpected12", 64'(q12.size() > 0), 64'd1);
            if (q12.size() > 0) begin
                e = q12.pop_front();
                checkOutput("byteData12", 64'(byte_data12), 64'(e[7:0]));
                checkOutput("byteLast12", 64'(byte_last12), 64'(e[8]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit sawValid;
        rst          = 1'b0;
        result32     = '0;
        valid32      = 1'b0;
        byte_ready32 = 1'b1;
        clear32      = 1'b0;
        result12     = '0;
        valid12      = 1'b0;
        byte_ready12 = 1'b1;
        clear12      = 1'b0;
        result8      = '0;
        valid8       = 1'b0;
        byte_ready8  = 1'b1;
        clear8       = 1'b0;

        // Reset values
        #12;
        checkOutput("rstByteData", 64'(byte_data32), 64'd0);
        checkOutput("rstByteValid", 64'(byte_valid32), 64'd0);
        checkOutput("rstByteLast", 64'(byte_last32), 64'd0);
        checkOutput("rstOverflow", 64'(overflow32), 64'd0);
        checkOutput("rstDropCount", 64'(drop_count32), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single result with first-byte latency
        seenValid  = 1'b0;
        validCount = 0;
        applyStimulus(32'hA1B2C3D4, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("latencyT1Idle", 64'(byte_valid32), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("latencyT2Valid", 64'(byte_valid32), 64'd1);
        checkOutput("firstByteD4", 64'(byte_data32), 64'hD4);
        waitDrain("drainSingle");
        checkOutput("singleCount", 64'(validCount), 64'd4);
        checkOutput("singleSpan", 64'(lastValid - firstValid), 64'd3);

        // Back-to-back results, no gap between them
        seenValid  = 1'b0;
        validCount = 0;
        applyStimulus(32'h11223344, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h55667788, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h99AABBCC, 1'b1, 1'b1, 1'b0, 1'b1);
        waitDrain("drainBackToBack");
        checkOutput("b2bCount", 64'(validCount), 64'd12);
        checkOutput("b2bSpan", 64'(lastValid - firstValid), 64'd11);

        // Back-pressure with ready pattern 1,0,0,1
        applyStimulus(32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0BADF00D, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            byte_ready32 = ((i % 4) == 0) || ((i % 4) == 3);
            @(posedge clk);
            #1;
        end
        byte_ready32 = 1'b1;
        waitDrain("drainBackPressure");

        // Overflow: 7 pushes while stalled, drop beats clear, then clear
        byte_ready32 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(32'hC0DE0000 + 32'(i), 1'b1, 1'b0, 1'b0, (i < 5));
        end
        @(negedge clk);
        checkOutput("dropCountTwo", 64'(drop_count32), 64'd2);
        checkOutput("overflowSet", 64'(overflow32), 64'd1);
        applyStimulus(32'hC0DE0007, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("clearDropCount", 64'(drop_count32), 64'd1);
        checkOutput("clearDropOverflow", 64'(overflow32), 64'd1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("clearedDropCount", 64'(drop_count32), 64'd0);
        checkOutput("clearedOverflow", 64'(overflow32), 64'd0);
        byte_ready32 = 1'b1;
        waitDrain("drainOverflow");

        // Full FIFO push accepted during the last-byte handshake
        byte_ready32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h7E570000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        checkOutput("fullSetupNoDrop", 64'(drop_count32), 64'd0);
        byte_ready32 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("lastByteBeforePush", 64'(byte_last32), 64'd1);
        applyStimulus(32'h7E570005, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fullPushNoDrop", 64'(drop_count32), 64'd0);
        checkOutput("fullPushNoOverflow", 64'(overflow32), 64'd0);
        waitDrain("drainFullPush");

        // Reset during the second byte aborts the result
        applyStimulus(32'h0F1E2D3C, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstByteData", 64'(byte_data32), 64'd0);
        checkOutput("midRstByteValid", 64'(byte_valid32), 64'd0);
        checkOutput("midRstByteLast", 64'(byte_last32), 64'd0);
        checkOutput("midRstOverflow", 64'(overflow32), 64'd0);
        checkOutput("midRstDropCount", 64'(drop_count32), 64'd0);
        q32.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (byte_valid32) sawValid = 1'b1;
        end
        checkOutput("emptyAfterReset", 64'(sawValid), 64'd0);

        // Odd width: 12-bit result in two bytes
        result12 = 12'hABC;
        valid12  = 1'b1;
        q12.push_back({1'b0, 8'hBC});
        q12.push_back({1'b1, 8'h0A});
        @(posedge clk);
        #1;
        valid12 = 1'b0;
        waitDrain("drainOddWidth");

        // Single-byte results: every byte is last
        result8 = 8'h5A;
        valid8  = 1'b1;
        @(posedge clk);
        #1;
        result8 = 8'hC3;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        @(negedge clk);
        checkOutput("oneByteValidA", 64'(byte_valid8), 64'd1);
        checkOutput("oneByteDataA", 64'(byte_data8), 64'h5A);
        checkOutput("oneByteLastA", 64'(byte_last8), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("oneByteDataB", 64'(byte_data8), 64'hC3);
        checkOutput("oneByteLastB", 64'(byte_last8), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("oneByteIdle", 64'(byte_valid8), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
